// File: rtl/hpc_and_sequencer.sv
// Sequencer for a 3-share (d=2) HPC masked AND gadget.
// Pairs each operand pair with one fresh randomness word, drives the gadget
// for exactly one cycle per operation, and collects the registered gadget
// result into a small output FIFO. Gadget inputs are forced to zero whenever
// nothing is issued so no stale shares or randomness ever reach the gadget.
//
// state  | meaning
// IDLE   | issue blocked, waiting for en
// RUN    | issue allowed while credit is available
// FLUSH  | results dropped, issue blocked for FLUSH_CYC cycles
module hpc_and_sequencer #(
  parameter int NSH       = 3,
  parameter int RND_W     = 6,
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 16,
  parameter int FLUSH_CYC = 2
) (
  input  logic             clock_0,
  input  logic             reset_0,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NSH-1:0]   in_a,
  input  logic [NSH-1:0]   in_b,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  input  logic [RND_W-1:0] rnd_data,
  output logic [NSH-1:0]   g_i0,
  output logic [NSH-1:0]   g_i1,
  output logic [RND_W-1:0] g_rand,
  input  logic [NSH-1:0]   g_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NSH-1:0]   out_z,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int FCN_W = $clog2(OUT_DEPTH + 1);
  localparam int CR_W  = FCN_W + 1;
  localparam int FL_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [FL_W-1:0]  fl_cnt_q, fl_cnt_d;
  logic             inflight_q;
  logic [FCN_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [NSH-1:0]   mem_q [OUT_DEPTH];
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic            issue;
  logic            push;
  logic            pop;
  logic            clr;
  logic [CR_W-1:0] credit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit counts free FIFO slots not already claimed by an in-flight result;
  // a pop this cycle frees a slot in time for a result issued now.
  assign out_valid = (fifo_cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign credit    = CR_W'(OUT_DEPTH) + CR_W'(pop) - CR_W'(fifo_cnt_q) - CR_W'(inflight_q);
  assign issue     = (state_q == ST_RUN) && in_valid && rnd_valid && !flush && (credit != '0);
  assign clr       = ((state_q == ST_RUN) && flush) || (state_q == ST_FLUSH);
  assign push      = inflight_q && !clr;

  assign in_ready  = issue;
  assign rnd_ready = issue;
  assign g_i0      = issue ? in_a : '0;
  assign g_i1      = issue ? in_b : '0;
  assign g_rand    = issue ? rnd_data : '0;

  assign out_z     = mem_q[rd_ptr_q];
  assign busy      = (state_q != ST_IDLE) || out_valid || inflight_q;
  assign op_count  = op_count_q;

  // Next-state logic for the sequencing FSM and its flush hold-off timer.
  always_comb begin
    state_d  = state_q;
    fl_cnt_d = fl_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en && !flush) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (flush) begin
          state_d  = ST_FLUSH;
          fl_cnt_d = FL_W'(FLUSH_CYC - 1);
        end else if (!en && !inflight_q && (fifo_cnt_q == '0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush) begin
          fl_cnt_d = FL_W'(FLUSH_CYC - 1);
        end else if (fl_cnt_q == '0) begin
          state_d = en ? ST_RUN : ST_IDLE;
        end else begin
          fl_cnt_d = fl_cnt_q - FL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO pointer/occupancy update; a flush discards everything buffered.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (clr) begin
      fifo_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + FCN_W'(1);
        2'b01:   fifo_cnt_d = fifo_cnt_q - FCN_W'(1);
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end
  end

  // Completed-operation counter sticks at all-ones instead of wrapping.
  always_comb begin
    op_count_d = op_count_q;
    if (pop && (op_count_q != '1)) op_count_d = op_count_q + CNT_W'(1);
  end

  // Control registers; inflight marks that g_o carries a valid result next cycle.
  always_ff @(posedge clock_0 or posedge reset_0) begin
    if (reset_0) begin
      state_q    <= ST_IDLE;
      fl_cnt_q   <= '0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      fl_cnt_q   <= fl_cnt_d;
      inflight_q <= issue;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      op_count_q <= op_count_d;
    end
  end

  // Result storage; cleared on reset so out_z reads zero until the first push.
  always_ff @(posedge clock_0 or posedge reset_0) begin
    if (reset_0) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= g_o;
    end
  end

  // Credit accounting must make overflow impossible.
  a_no_overflow: assert property (@(posedge clock_0) disable iff (reset_0)
    !(push && !pop && (fifo_cnt_q == FCN_W'(OUT_DEPTH))));

endmodule

// File: tb/tb_hpc_and_sequencer.sv
// Bench for hpc_and_sequencer: behavioural registered gadget, scoreboard of
// expected share vectors, and directed scenarios for backpressure, randomness
// starvation, flush, counter saturation and mid-burst reset.
module tb_hpc_and_sequencer;

  localparam int CW = 6;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clock_0, reset_0, en, flush;
  logic          in_valid, in_ready, rnd_valid, rnd_ready;
  logic [2:0]    in_a, in_b, g_i0, g_i1, g_o, out_z;
  logic [5:0]    rnd_data, g_rand;
  logic          out_valid, out_ready, busy;
  logic [CW-1:0] op_count;

  typedef struct packed {
    logic [2:0] z;
    logic       p;
  } exp_t;

  exp_t          exp_q[$];
  logic [CW-1:0] exp_cnt;
  int            n_chk, n_err;

  hpc_and_sequencer #(.CNT_W(CW)) dut (
    .clock_0(clock_0), .reset_0(reset_0), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
    .g_i0(g_i0), .g_i1(g_i1), .g_rand(g_rand), .g_o(g_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .busy(busy), .op_count(op_count)
  );

  initial clock_0 = 1'b0;
  always #5 clock_0 = ~clock_0;

  // Share-level gadget stand-in: XOR of output shares equals the unmasked AND,
  // every randomness bit lands in two shares.
  function automatic logic [2:0] gadget_f(input logic [2:0] a, input logic [2:0] b,
                                          input logic [5:0] r);
    logic p;
    logic [2:0] z;
    p    = (^a) & (^b);
    z[0] = p ^ r[0] ^ r[3] ^ r[5];
    z[1] = r[0] ^ r[1] ^ r[2] ^ r[4] ^ a[1];
    z[2] = r[3] ^ r[5] ^ r[1] ^ r[2] ^ r[4] ^ a[1];
    return z;
  endfunction

  always @(posedge clock_0) g_o <= gadget_f(g_i0, g_i1, g_rand);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: push on accepted issue, pop and compare on output handshake.
  always @(negedge clock_0) begin
    exp_t e;
    chk("op_count", op_count, exp_cnt);
    if (in_ready) begin
      chk("g_i0", g_i0, in_a);
      chk("g_i1", g_i1, in_b);
      chk("g_rand", g_rand, rnd_data);
      exp_q.push_back(exp_t'{gadget_f(in_a, in_b, rnd_data), (^in_a) & (^in_b)});
    end else begin
      chk("g_zero", {g_i0, g_i1, g_rand}, 12'h000);
    end
    if (out_valid && out_ready) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_z", out_z, e.z);
        chk("xor_z", ^out_z, e.p);
      end
      if (exp_cnt != CMAX) exp_cnt = exp_cnt + 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clock_0);
    #2;
  endtask

  task automatic drive_rand();
    in_a     = 3'($urandom_range(0, 7));
    in_b     = 3'($urandom_range(0, 7));
    rnd_data = 6'($urandom_range(0, 63));
  endtask

  task automatic issue_n(input int n, input logic ordy);
    int got = 0;
    int guard = 0;
    in_valid  = 1'b1;
    rnd_valid = 1'b1;
    out_ready = ordy;
    while (got < n && guard < 500) begin
      drive_rand();
      #1;
      if (in_ready) got++;
      cyc();
      guard++;
    end
    in_valid = 1'b0;
    chk("issue_n", got, n);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) cyc();
  endtask

  task automatic do_reset();
    reset_0   = 1'b1;
    exp_cnt   = '0;
    exp_q.delete();
    en        = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    rnd_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) cyc();
    reset_0 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int acc;
    logic [CW-1:0] saved;
    n_chk = 0;
    n_err = 0;
    exp_cnt = '0;
    in_a = '0;
    in_b = '0;
    rnd_data = '0;
    reset_0 = 1'b1;
    en = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    rnd_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_outs", {in_ready, rnd_ready, out_valid, busy}, 4'b0000);
    chk("rst_gadget", {g_i0, g_i1, g_rand, out_z}, 15'h0000);
    chk("rst_op_count", op_count, 0);
    reset_0 = 1'b0;
    cyc();

    // Continuous fixed operands
    en = 1'b1; in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
    in_a = 3'b101; in_b = 3'b011; rnd_data = 6'h2A;
    #1;
    chk("t1_idle_block", in_ready, 0);
    cyc();
    chk("t1_rdy_first", {in_ready, rnd_ready}, 2'b11);
    chk("t1_gi0", g_i0, 3'b101);
    chk("t1_grand", g_rand, 6'h2A);
    cyc();
    chk("t1_ov_1edge", out_valid, 0);
    chk("t1_rdy", in_ready, 1);
    cyc();
    chk("t1_ov_2edge", out_valid, 1);
    chk("t1_z_fixed", out_z, gadget_f(3'b101, 3'b011, 6'h2A));
    repeat (6) begin
      cyc();
      chk("t1_stream", {in_ready, out_valid}, 2'b11);
    end
    repeat (12) begin
      drive_rand();
      cyc();
      chk("t1_rand_rdy", in_ready, 1);
    end
    drain();

    // Backpressure: only two operations fit
    out_ready = 1'b0; in_valid = 1'b1; rnd_valid = 1'b1;
    acc = 0;
    repeat (6) begin
      drive_rand();
      #1;
      if (in_ready) acc++;
      cyc();
    end
    chk("t2_accepted", acc, 2);
    chk("t2_blocked", {in_ready, rnd_ready, out_valid}, 3'b001);
    out_ready = 1'b1;
    #1;
    chk("t2_resume", in_ready, 1);
    cyc();
    drain();

    // Randomness starvation
    in_valid = 1'b1; rnd_valid = 1'b0;
    repeat (5) begin
      drive_rand();
      #1;
      chk("t3_rdy", {in_ready, rnd_ready}, 2'b00);
      chk("t3_gzero", {g_i0, g_i1, g_rand}, 12'h000);
      cyc();
    end
    in_valid = 1'b0; rnd_valid = 1'b1;
    cyc();

    // Flush with one result buffered and one in flight
    issue_n(2, 1'b0);
    chk("t4_buffered", out_valid, 1);
    saved = exp_cnt;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    exp_q.delete();
    chk("t4_ov_cleared", {out_valid, busy}, 2'b01);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("t4_flush_block0", in_ready, 0);
    cyc();
    chk("t4_flush_block1", {in_ready, out_valid}, 2'b00);
    cyc();
    chk("t4_back_run", in_ready, 1);
    chk("t4_cnt_kept", op_count, saved);
    drain();

    // Counter saturation
    do_reset();
    en = 1'b1;
    issue_n(int'(CMAX) - 1, 1'b1);
    drain();
    chk("t5_cnt_max_m1", op_count, CMAX - 1'b1);
    issue_n(3, 1'b1);
    drain();
    chk("t5_cnt_sat", op_count, CMAX);
    repeat (3) cyc();
    chk("t5_cnt_hold", op_count, CMAX);

    // Asynchronous reset mid-burst
    in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
    repeat (5) begin
      drive_rand();
      cyc();
    end
    #1;
    reset_0 = 1'b1;
    exp_cnt = '0;
    exp_q.delete();
    #1;
    chk("t6_rst_outs", {in_ready, rnd_ready, out_valid, busy}, 4'b0000);
    chk("t6_rst_gadget", {g_i0, g_i1, g_rand, out_z}, 15'h0000);
    chk("t6_rst_cnt", op_count, 0);
    repeat (2) cyc();
    reset_0 = 1'b0;
    issue_n(1, 1'b1);
    drain();
    chk("t6_first_op_cnt", op_count, 1);
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
